// File: rtl/example2_core.sv
// Registered two-input logic unit with a saturating rising-edge counter on y
// and an overlapping 1-0-1 pattern detector on the y stream.
module example2_core #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       op,
    input  logic             clr,
    output logic             y,
    output logic [CNT_W-1:0] edge_cnt,
    output logic             seq_hit
);

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S0  = 2'b00,
        S1  = 2'b01,
        S10 = 2'b10
    } state_e;

    logic   f_next;
    logic   y_d;
    logic   rise;
    logic   cnt_max;
    state_e state_q;
    state_e state_d;
    logic   hit_d;

    always_comb begin
        f_next = 1'b0;
        unique case (op_e'(op))
            OP_AND:  f_next = a & b;
            OP_OR:   f_next = a | b;
            OP_XOR:  f_next = a ^ b;
            OP_NAND: f_next = ~(a & b);
            default: f_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y   <= 1'b0;
            y_d <= 1'b0;
        end else begin
            y   <= f_next;
            y_d <= y;
        end
    end

    assign rise    = y & ~y_d;
    assign cnt_max = (edge_cnt == '1);

    // clr takes priority over a concurrent rise; the counter holds at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            edge_cnt <= '0;
        end else if (clr) begin
            edge_cnt <= '0;
        end else if (rise && !cnt_max) begin
            edge_cnt <= edge_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S0;
            seq_hit <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_hit <= hit_d;
        end
    end

    // S10 returns to S1 on a hit so that 1,0,1,0,1 reports twice
    always_comb begin
        state_d = state_q;
        hit_d   = 1'b0;
        unique case (state_q)
            S0:  if (y) state_d = S1;
            S1:  if (!y) state_d = S10;
            S10: begin
                if (y) begin
                    state_d = S1;
                    hit_d   = 1'b1;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

endmodule

// File: tb/tb_example2_core.sv
// Self-checking bench for example2_core: directed test-plan steps plus random
// traffic, compared against a history-based behavioural model.
module tb_example2_core;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst, a, b, clr;
    logic [1:0]       op;
    logic             y;
    logic [CNT_W-1:0] edge_cnt;
    logic             seq_hit;

    int checks = 0;
    int errors = 0;

    // model state
    int unsigned m_y, m_cnt, m_hit;
    int unsigned hist[$];
    int unsigned hits_seen;
    logic [3:0]  tbl [4];

    example2_core #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .op(op), .clr(clr),
        .y(y), .edge_cnt(edge_cnt), .seq_hit(seq_hit)
    );

    always #5 clk = ~clk;

    function automatic int unsigned func(input int unsigned o, input int unsigned x, input int unsigned z);
        case (o)
            0:       return (x == 1 && z == 1) ? 1 : 0;
            1:       return (x == 1 || z == 1) ? 1 : 0;
            2:       return (x != z) ? 1 : 0;
            default: return (x == 1 && z == 1) ? 0 : 1;
        endcase
    endfunction

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Model: y history since reset; a rise is a 0->1 step between the last two
    // sampled values, a hit is the last three samples reading 1,0,1.
    task automatic model_edge(input logic r, input logic c, input logic aa, input logic bb, input logic [1:0] o);
        int unsigned n;
        if (r) begin
            m_y = 0; m_cnt = 0; m_hit = 0;
            hist.delete();
        end else begin
            hist.push_back(m_y);
            n = hist.size();
            if (c) m_cnt = 0;
            else if (n >= 2 && hist[n-1] == 1 && hist[n-2] == 0 && m_cnt < CNT_MAX) m_cnt++;
            else if (n == 1 && hist[0] == 1 && m_cnt < CNT_MAX) m_cnt++;
            m_hit = (n >= 3 && hist[n-3] == 1 && hist[n-2] == 0 && hist[n-1] == 1) ? 1 : 0;
            m_y = func(o, aa, bb);
        end
    endtask

    task automatic step(input logic r, input logic c, input logic aa, input logic bb, input logic [1:0] o);
        rst = r; clr = c; a = aa; b = bb; op = o;
        @(posedge clk);
        model_edge(r, c, aa, bb, o);
        #1;
        chk("y", y, m_y);
        chk("edge_cnt", edge_cnt, m_cnt);
        chk("seq_hit", seq_hit, m_hit);
        if (seq_hit === 1'b1) hits_seen++;
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
    endtask

    // y follows a one edge later (op=AND, b=1)
    task automatic pulse_pairs(input int n);
        for (int i = 0; i < n; i++) begin
            step(0, 0, 1, 1, 0);
            step(0, 0, 0, 1, 0);
        end
    endtask

    initial begin
        logic [8:0] pat;
        tbl[0] = 4'b1000; tbl[1] = 4'b1110; tbl[2] = 4'b0110; tbl[3] = 4'b0111;
        m_y = 0; m_cnt = 0; m_hit = 0; hits_seen = 0;
        rst = 1; clr = 1; a = 1; b = 1; op = 2'b01;

        // reset with a=b=1, op=OR, clr asserted as well
        step(1, 1, 1, 1, 2'b01);
        step(1, 1, 1, 1, 2'b01);
        chk("rst_y", y, 0);
        chk("rst_cnt", edge_cnt, 0);
        chk("rst_hit", seq_hit, 0);
        step(0, 0, 1, 1, 2'b01);
        chk("post_rst_y", y, 1);

        // function sweep against the truth table
        for (int o = 0; o < 4; o++)
            for (int ab = 0; ab < 4; ab++) begin
                step(0, 0, ab[1], ab[0], o[1:0]);
                chk($sformatf("func_op%0d_ab%0d", o, ab), y, tbl[o][ab]);
            end

        // counting and saturation
        do_reset();
        pulse_pairs(3);
        chk("cnt_3", edge_cnt, 3);
        pulse_pairs(300);
        chk("cnt_sat", edge_cnt, 255);

        // clr beats a concurrent rise
        do_reset();
        pulse_pairs(5);
        chk("cnt_5", edge_cnt, 5);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        chk("clr_prio", edge_cnt, 0);
        pulse_pairs(1);
        chk("cnt_after_clr", edge_cnt, 1);

        // pattern 1,0,1,0,1,1,0,0,1 on y: two pulses
        do_reset();
        hits_seen = 0;
        pat = 9'b100110101;
        for (int i = 0; i < 9; i++) step(0, 0, pat[i], 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("pattern_hits", hits_seen, 2);

        // reset mid-operation with FSM in S10 and count 7
        do_reset();
        pulse_pairs(7);
        step(0, 0, 0, 1, 0);
        chk("pre_rst_cnt", edge_cnt, 7);
        hits_seen = 0;
        do_reset();
        chk("mid_rst_y", y, 0);
        chk("mid_rst_cnt", edge_cnt, 0);
        chk("mid_rst_hit", seq_hit, 0);
        step(0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("mid_rst_nohit", hits_seen, 0);
        chk("mid_rst_cnt1", edge_cnt, 1);

        // random traffic
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 19) == 0),
                 $urandom_range(0, 1), $urandom_range(0, 1), 2'($urandom_range(0, 3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/example2_core.md
Name:
example2_core

Overview:
- Small registered two-input logic unit with output-stream monitoring.
- Each cycle it computes a selectable Boolean function of two 1-bit inputs into a registered output `y`.
- It counts rising edges of `y` in a saturating counter.
- An FSM flags the 1-0-1 pattern on `y`.
- Used as a leaf block beside simple control logic. Single clock domain.

Parameters:
- CNT_W, 8, width of the rising-edge counter `edge_cnt` (≥2).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- a  input  1  operand A.
- b  input  1  operand B.
- op  input  2  function select: 00 AND, 01 OR, 10 XOR, 11 NAND.
- clr  input  1  synchronous clear of `edge_cnt` only.
- y  output  1  registered result of op(a,b).
- edge_cnt  output  CNT_W  saturating count of 0→1 transitions of `y`.
- seq_hit  output  1  one-cycle pulse on 1-0-1 detection on `y`.

Behaviour:
- Interface: one clock; reset is synchronous and active-high; clock port `clk`, reset port `rst`.
- Reset (rst=1 at a rising edge):
  - y=0, y_d (internal previous-y) = 0, edge_cnt=0, seq_hit=0, FSM=S0.
  - rst overrides all other inputs, including clr.
  - Reset asserted mid-operation discards all history. The first post-reset cycle behaves as if y had been 0.
- Function:
  - y <= f(op, a, b) on every non-reset edge.
  - Latency: 1 cycle from sampling a/b/op to y. No handshake; y updates every cycle.
- Edge counter:
  - y_d <= y every cycle.
  - A rise means y=1 and y_d=0 at an edge.
  - On a rise, edge_cnt <= edge_cnt+1 unless edge_cnt = 2^CNT_W−1; it then holds (saturates, no wrap).
  - clr=1: edge_cnt <= 0 at that edge and the concurrent rise is not counted (clr beats increment).
  - clr does not affect y, the FSM or seq_hit.
- Pattern FSM (samples current y at each edge, overlapping detection):
  - S0: y=1 → S1; else stay S0.
  - S1: y=0 → S10; else stay S1.
  - S10: y=1 → S1 with seq_hit<=1; y=0 → S0.
  - seq_hit is registered. It is 1 for exactly the one cycle after the edge on which S10 sampled y=1, otherwise 0.
  - Overlap: y stream 1,0,1,0,1 gives two pulses.
- Timing for a bench with a 10 ns clock:
  - a/b applied before edge k → y valid after edge k.
  - y sampled by the counter and FSM at edge k+1.
  - edge_cnt / seq_hit change after edge k+1.
- No combinational paths from inputs to outputs. All outputs come directly from flops.

Test Plan:
- Reset: rst=1 for 2 edges with a=b=1, op=01 → y=0, edge_cnt=0, seq_hit=0. After release, y=1 one edge later.
- Function sweep: for each op in 00..11 apply all four (a,b) combos.
  - Required y one edge later, per (a,b) = 00,01,10,11:
  - AND 0,0,0,1; OR 0,1,1,1; XOR 0,1,1,0; NAND 1,1,1,0.
- Edge count with saturation (CNT_W=8):
  - Toggle y (op=00, b=1, a alternating) for 3 rises → edge_cnt=3.
  - Keep toggling for 300 rises → edge_cnt holds at 255.
- clr priority:
  - clr=1 on the same edge as a y rise with edge_cnt=5 → edge_cnt=0, not 1.
  - Next rise → 1.
- Pattern:
  - Drive y stream 1,0,1,0,1,1,0,0,1 → seq_hit pulses exactly twice, each one cycle wide.
  - Pulses follow the 3rd and 5th samples; none for the trailing 0,0,1.
- Reset mid-operation:
  - Assert rst while FSM is in S10 and edge_cnt=7 → all outputs 0.
  - Then drive y=1 → no seq_hit, and edge_cnt=1 after the rise.
